imem_loader: RTL and testbench

Boot-time program loader between the testbench/host stream and the single-cycle core's instruction memory. Replaces hierarchical `mem[]` pokes and direct `next_pc` forcing with a handshaked word stream. The stream carries a length header, N instruction words and an XOR checksum. The block writes the words into imem, pads the rest of imem with NOPs, and holds the core in reset until the image is verified.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
//   state_t          : loader FSM states
//   NOP_WORD_DEFAULT : default imem pad word (addi x0,x0,0)
package loader_pkg;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        LOAD = 3'd1,
        CHK  = 3'd2,
        FILL = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/imem_loader.sv
// Boot-time program loader. Accepts a handshaked word stream made of a
// length header N, N instruction words and an XOR checksum beat (s_last).
// Payload words go into imem, the remainder of imem is padded with NOPs,
// and the core is held in reset until the image has been verified.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   s_valid/s_ready/s_data/s_last   input word stream
//   reload                      pulse in RUN/ERR restarts loading
//   imem_we/imem_waddr/imem_wdata   registered imem write port
//   cpu_rst_n, boot_pc          core reset and PC reset value
//   load_done, load_err         image accepted / rejected
//   loaded_words                latched header value N
//
// state | meaning
// ------+-------------------------------------------------------------
// HDR   | waiting for length header N
// LOAD  | writing payload words into imem, accumulating XOR
// CHK   | waiting for checksum beat (must carry s_last)
// FILL  | padding addresses N..IMEM_DEPTH-1 with NOP_WORD
// RUN   | image verified, core released from reset
// ERR   | image rejected, core held in reset
module imem_loader
    import loader_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter int               IMEM_DEPTH = 256,
    parameter int               ADDR_W     = $clog2(IMEM_DEPTH),
    parameter logic [XLEN-1:0]  BOOT_PC    = '0,
    parameter logic [XLEN-1:0]  NOP_WORD   = XLEN'(NOP_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [XLEN-1:0]   s_data,
    input  logic              s_last,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              cpu_rst_n,
    output logic [XLEN-1:0]   boot_pc,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   loaded_words
);

    localparam logic [XLEN-1:0] DEPTH_X   = XLEN'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(IMEM_DEPTH - 1);

    state_t            state;
    logic [XLEN-1:0]   n_words;
    logic [XLEN-1:0]   acc;
    logic [ADDR_W:0]   addr_cnt;
    logic [ADDR_W:0]   addr_nxt;
    logic              accept;

    assign boot_pc  = BOOT_PC;
    assign s_ready  = (state == HDR) || (state == LOAD) || (state == CHK);
    assign accept   = s_valid && s_ready;
    assign addr_nxt = addr_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HDR;
            n_words      <= '0;
            acc          <= '0;
            addr_cnt     <= '0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            cpu_rst_n    <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            loaded_words <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                HDR: begin
                    if (accept) begin
                        n_words      <= s_data;
                        loaded_words <= s_data[ADDR_W:0];
                        acc          <= '0;
                        addr_cnt     <= '0;
                        // Full-width compare so huge headers cannot alias
                        // into a legal truncated length.
                        if (s_last || (s_data > DEPTH_X))
                            state <= ERR;
                        else if (s_data == '0)
                            state <= CHK;
                        else
                            state <= LOAD;
                    end
                end

                LOAD: begin
                    if (accept) begin
                        if (s_last) begin
                            // A premature final beat is the error itself;
                            // it is not treated as an instruction.
                            state <= ERR;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_waddr <= addr_cnt[ADDR_W-1:0];
                            imem_wdata <= s_data;
                            acc        <= acc ^ s_data;
                            addr_cnt   <= addr_nxt;
                            if (XLEN'(addr_nxt) == n_words)
                                state <= CHK;
                        end
                    end
                end

                CHK: begin
                    if (accept) begin
                        if (!s_last || (s_data != acc))
                            state <= ERR;
                        else if (n_words == DEPTH_X)
                            state <= RUN;
                        else
                            state <= FILL;
                    end
                end

                FILL: begin
                    // addr_cnt already equals N on entry.
                    imem_we    <= 1'b1;
                    imem_waddr <= addr_cnt[ADDR_W-1:0];
                    imem_wdata <= NOP_WORD;
                    addr_cnt   <= addr_nxt;
                    if (addr_cnt == LAST_ADDR)
                        state <= RUN;
                end

                RUN: begin
                    if (reload) begin
                        state     <= HDR;
                        cpu_rst_n <= 1'b0;
                        load_done <= 1'b0;
                    end else begin
                        cpu_rst_n <= 1'b1;
                        load_done <= 1'b1;
                    end
                end

                ERR: begin
                    cpu_rst_n <= 1'b0;
                    if (reload) begin
                        state    <= HDR;
                        load_err <= 1'b0;
                    end else begin
                        load_err <= 1'b1;
                    end
                end

                default: state <= ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   s_data = '0;
    logic          s_last = 1'b0;
    logic          reload = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_n;
    logic [31:0]   boot_pc;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   loaded_words;

    int checks = 0;
    int errors = 0;

    logic [35:0] exp_q[$];   // {addr, data}
    logic [32:0] beats[$];   // {last, data}

    imem_loader #(.XLEN(32), .IMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .reload(reload),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_rst_n(cpu_rst_n), .boot_pc(boot_pc),
        .load_done(load_done), .load_err(load_err), .loaded_words(loaded_words)
    );

    always #5 clk = ~clk;

    // Monitor: every presented imem write must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            logic [35:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL imem_write unexpected: addr=%0d data=%08h, required none",
                         imem_waddr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_waddr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL imem_write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             imem_waddr, imem_wdata, e[35:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"},      64'(s_ready), 64'd1);
        check({tag, "_imem_we"},      64'(imem_we), 64'd0);
        check({tag, "_imem_waddr"},   64'(imem_waddr), 64'd0);
        check({tag, "_imem_wdata"},   64'(imem_wdata), 64'd0);
        check({tag, "_cpu_rst_n"},    64'(cpu_rst_n), 64'd0);
        check({tag, "_load_done"},    64'(load_done), 64'd0);
        check({tag, "_load_err"},     64'(load_err), 64'd0);
        check({tag, "_loaded_words"}, 64'(loaded_words), 64'd0);
        check({tag, "_boot_pc"},      64'(boot_pc), 64'd0);
    endtask

    task automatic send_beat(input logic [32:0] b, input bit gaps);
        int tries;
        if (gaps) begin
            int n = $urandom_range(0, 2);
            repeat (n) begin
                @(negedge clk);
                s_valid = 1'b0;
            end
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b[31:0];
        s_last  = b[32];
        tries = 0;
        while (!s_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 50) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout: got 0, required 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Build a well-formed image of n words; optionally corrupt the checksum.
    task automatic build_image(input int n, input bit bad_chk);
        logic [31:0] x = '0;
        beats.delete();
        beats.push_back({1'b0, 32'(n)});
        for (int i = 0; i < n; i++) begin
            logic [31:0] w = $urandom;
            beats.push_back({1'b0, w});
            x ^= w;
        end
        if (bad_chk) x ^= 32'h1 << $urandom_range(0, 31);
        beats.push_back({1'b1, x});
    endtask

    // Reference model: interpret the beat list, queue expected writes,
    // send only the beats the loader will accept, and check the outcome.
    task automatic run_image(input string name, input bit gaps);
        logic [31:0] hdr;
        logic [31:0] x;
        bit          err;
        int          consumed;
        int          waited;
        hdr = beats[0][31:0];
        err = 1'b0;
        x   = '0;
        consumed = 1;
        if (beats[0][32] || hdr > DEPTH) begin
            err = 1'b1;
        end else begin
            for (int i = 0; i < int'(hdr); i++) begin
                consumed = i + 2;
                if (beats[1 + i][32]) begin
                    err = 1'b1;
                    break;
                end
                exp_q.push_back({AW'(i), beats[1 + i][31:0]});
                x ^= beats[1 + i][31:0];
            end
            if (!err) begin
                consumed = int'(hdr) + 2;
                if (!beats[1 + hdr][32] || beats[1 + hdr][31:0] != x)
                    err = 1'b1;
                else
                    for (int a = int'(hdr); a < DEPTH; a++)
                        exp_q.push_back({AW'(a), NOP});
            end
        end
        for (int i = 0; i < consumed; i++) send_beat(beats[i], gaps);
        waited = 0;
        while (!(load_done || load_err) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        #1;
        check({name, "_outcome_done_err"}, 64'({load_done, load_err}), 64'({!err, err}));
        check({name, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(!err));
        check({name, "_s_ready"}, 64'(s_ready), 64'd0);
        check({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        if (!err) check({name, "_loaded_words"}, 64'(loaded_words), 64'(hdr));
        exp_q.delete();
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_clears_done", 64'(load_done), 64'd0);
        check("reload_clears_err", 64'(load_err), 64'd0);
        check("reload_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("reload_s_ready", 64'(s_ready), 64'd1);
    endtask

    initial begin
        #1;
        check_reset_values("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("after_reset");

        // Reference stream from the bring-up program.
        beats.delete();
        beats.push_back({1'b0, 32'd2});
        beats.push_back({1'b0, 32'h0050_0093});
        beats.push_back({1'b0, 32'h0030_0113});
        beats.push_back({1'b1, 32'h0060_0180});
        run_image("ref_ok", 1'b0);

        pulse_reload();
        beats[3] = {1'b1, 32'h0060_0181};
        run_image("ref_badchk", 1'b0);

        pulse_reload();
        beats.delete();
        beats.push_back({1'b0, 32'd17});
        beats.push_back({1'b1, 32'd0});
        run_image("hdr_17", 1'b0);

        pulse_reload();
        beats.delete();
        beats.push_back({1'b0, 32'h8000_0004});
        run_image("hdr_huge", 1'b0);

        pulse_reload();
        beats.delete();
        beats.push_back({1'b1, 32'd3});
        run_image("hdr_last", 1'b0);

        pulse_reload();
        build_image(0, 1'b0);
        run_image("len_0", 1'b0);

        pulse_reload();
        build_image(DEPTH, 1'b0);
        run_image("len_full", 1'b0);

        pulse_reload();
        build_image(3, 1'b0);
        beats[2][32] = 1'b1;
        run_image("early_last", 1'b0);

        pulse_reload();
        build_image(5, 1'b0);
        beats[6][32] = 1'b0;
        beats.push_back({1'b1, 32'd0});
        run_image("chk_no_last", 1'b0);

        pulse_reload();
        build_image(3, 1'b0);
        run_image("after_err", 1'b0);

        // Reset in the middle of a gapped 9-word load.
        pulse_reload();
        build_image(9, 1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back({AW'(i), beats[1 + i][31:0]});
        for (int i = 0; i < 5; i++) send_beat(beats[i], 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midload_pending_writes", 64'(exp_q.size()), 64'd0);
        check_reset_values("midload_rst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        build_image(9, 1'b0);
        run_image("after_rst", 1'b1);

        for (int k = 0; k < 8; k++) begin
            pulse_reload();
            build_image($urandom_range(0, DEPTH), ($urandom_range(0, 3) == 0));
            run_image($sformatf("rand%0d", k), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
